// File: rtl/axil_arb_pkg.sv
// Shared definitions for the two-master AXI-Lite memory arbiter:
// FSM state encoding and default channel widths.
package axil_arb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_ADDR = 3'd3,
      WR_DATA = 3'd4,
      WR_RESP = 3'd5
   } state_t;

   localparam int ADDR_WDTH_DEF = 4;
   localparam int DATA_WDTH_DEF = 32;
   localparam int RESP_WDTH_DEF = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-requester round-robin pick; the history bit lives in the caller.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_owner,
   input  logic       enable,
   output logic       gnt
);

   always_comb begin
      gnt = 1'b0;
      if (enable) begin
         if (req == 2'b11) gnt = ~last_owner;
         else              gnt = req[1];
      end
   end

endmodule

// File: rtl/axil_mem_arbiter.sv
// Two-master AXI-Lite arbiter in front of one memory slave; one whole
// transaction (AR+R or AW+W+B) is owned by one master at a time.
module axil_mem_arbiter
   import axil_arb_pkg::*;
#(
   parameter int ADDR_WDTH = ADDR_WDTH_DEF,
   parameter int DATA_WDTH = DATA_WDTH_DEF,
   parameter int RESP_WDTH = RESP_WDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m0_ar_valid,
   input  logic [ADDR_WDTH-1:0] m0_ar_address,
   output logic                 m0_ar_ready,
   output logic                 m0_r_valid,
   output logic [DATA_WDTH-1:0] m0_r_data,
   output logic [RESP_WDTH-1:0] m0_r_resp,
   input  logic                 m0_r_ready,
   input  logic                 m0_aw_valid,
   input  logic [ADDR_WDTH-1:0] m0_aw_address,
   output logic                 m0_aw_ready,
   input  logic                 m0_w_valid,
   input  logic [DATA_WDTH-1:0] m0_w_data,
   output logic                 m0_w_ready,
   output logic                 m0_b_valid,
   output logic [RESP_WDTH-1:0] m0_b_resp,
   input  logic                 m0_b_ready,
   input  logic                 m1_ar_valid,
   input  logic [ADDR_WDTH-1:0] m1_ar_address,
   output logic                 m1_ar_ready,
   output logic                 m1_r_valid,
   output logic [DATA_WDTH-1:0] m1_r_data,
   output logic [RESP_WDTH-1:0] m1_r_resp,
   input  logic                 m1_r_ready,
   input  logic                 m1_aw_valid,
   input  logic [ADDR_WDTH-1:0] m1_aw_address,
   output logic                 m1_aw_ready,
   input  logic                 m1_w_valid,
   input  logic [DATA_WDTH-1:0] m1_w_data,
   output logic                 m1_w_ready,
   output logic                 m1_b_valid,
   output logic [RESP_WDTH-1:0] m1_b_resp,
   input  logic                 m1_b_ready,
   output logic                 s_ar_valid,
   output logic [ADDR_WDTH-1:0] s_ar_address,
   input  logic                 s_ar_ready,
   input  logic                 s_r_valid,
   input  logic [DATA_WDTH-1:0] s_r_data,
   input  logic [RESP_WDTH-1:0] s_r_resp,
   output logic                 s_r_ready,
   output logic                 s_aw_valid,
   output logic [ADDR_WDTH-1:0] s_aw_address,
   input  logic                 s_aw_ready,
   output logic                 s_w_valid,
   output logic [DATA_WDTH-1:0] s_w_data,
   input  logic                 s_w_ready,
   input  logic                 s_b_valid,
   input  logic [RESP_WDTH-1:0] s_b_resp,
   output logic                 s_b_ready,
   output logic                 busy,
   output logic                 grant_id
);

   state_t     state, state_nxt;
   logic       last_owner;
   logic [1:0] wr_pri;
   logic       gnt;
   logic       grant;
   logic       grant_wr;

   // Per-master views indexed by owner so the muxes stay regular.
   logic [1:0]           ar_v, aw_v, w_v, r_rdy, b_rdy, req;
   logic [ADDR_WDTH-1:0] ar_a [2];
   logic [ADDR_WDTH-1:0] aw_a [2];
   logic [DATA_WDTH-1:0] w_d  [2];

   assign ar_v  = {m1_ar_valid, m0_ar_valid};
   assign aw_v  = {m1_aw_valid, m0_aw_valid};
   assign w_v   = {m1_w_valid,  m0_w_valid};
   assign r_rdy = {m1_r_ready,  m0_r_ready};
   assign b_rdy = {m1_b_ready,  m0_b_ready};
   assign ar_a[0] = m0_ar_address;
   assign ar_a[1] = m1_ar_address;
   assign aw_a[0] = m0_aw_address;
   assign aw_a[1] = m1_aw_address;
   assign w_d[0]  = m0_w_data;
   assign w_d[1]  = m1_w_data;
   assign req     = ar_v | aw_v;

   rr_arbiter2 u_rr (
      .req        (req),
      .last_owner (last_owner),
      .enable     (state == IDLE),
      .gnt        (gnt)
   );

   assign grant    = (state == IDLE) && (req != 2'b00);
   assign grant_wr = aw_v[gnt] && (!ar_v[gnt] || wr_pri[gnt]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         grant_id   <= 1'b0;
         last_owner <= 1'b1;
         wr_pri     <= 2'b00;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         if (grant) begin
            grant_id      <= gnt;
            last_owner    <= gnt;
            wr_pri[gnt]   <= ~wr_pri[gnt];
         end else if (state_nxt == IDLE) begin
            grant_id <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      s_ar_valid   = 1'b0;
      s_ar_address = '0;
      s_r_ready    = 1'b0;
      s_aw_valid   = 1'b0;
      s_aw_address = '0;
      s_w_valid    = 1'b0;
      s_w_data     = '0;
      s_b_ready    = 1'b0;
      m0_ar_ready  = 1'b0;
      m0_r_valid   = 1'b0;
      m0_r_data    = '0;
      m0_r_resp    = '0;
      m0_aw_ready  = 1'b0;
      m0_w_ready   = 1'b0;
      m0_b_valid   = 1'b0;
      m0_b_resp    = '0;
      m1_ar_ready  = 1'b0;
      m1_r_valid   = 1'b0;
      m1_r_data    = '0;
      m1_r_resp    = '0;
      m1_aw_ready  = 1'b0;
      m1_w_ready   = 1'b0;
      m1_b_valid   = 1'b0;
      m1_b_resp    = '0;
      case (state)
         IDLE: begin
            if (grant) state_nxt = grant_wr ? WR_ADDR : RD_ADDR;
         end
         RD_ADDR: begin
            s_ar_valid   = ar_v[grant_id];
            s_ar_address = ar_a[grant_id];
            if (grant_id) m1_ar_ready = s_ar_ready;
            else          m0_ar_ready = s_ar_ready;
            if (s_ar_valid && s_ar_ready) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            s_r_ready = r_rdy[grant_id];
            if (grant_id) begin
               m1_r_valid = s_r_valid;
               m1_r_data  = s_r_data;
               m1_r_resp  = s_r_resp;
            end else begin
               m0_r_valid = s_r_valid;
               m0_r_data  = s_r_data;
               m0_r_resp  = s_r_resp;
            end
            if (s_r_valid && s_r_ready) state_nxt = IDLE;
         end
         WR_ADDR: begin
            s_aw_valid   = aw_v[grant_id];
            s_aw_address = aw_a[grant_id];
            if (grant_id) m1_aw_ready = s_aw_ready;
            else          m0_aw_ready = s_aw_ready;
            if (s_aw_valid && s_aw_ready) state_nxt = WR_DATA;
         end
         WR_DATA: begin
            s_w_valid = w_v[grant_id];
            s_w_data  = w_d[grant_id];
            if (grant_id) m1_w_ready = s_w_ready;
            else          m0_w_ready = s_w_ready;
            if (s_w_valid && s_w_ready) state_nxt = WR_RESP;
         end
         WR_RESP: begin
            s_b_ready = b_rdy[grant_id];
            if (grant_id) begin
               m1_b_valid = s_b_valid;
               m1_b_resp  = s_b_resp;
            end else begin
               m0_b_valid = s_b_valid;
               m0_b_resp  = s_b_resp;
            end
            if (s_b_valid && s_b_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Directed bench for axil_mem_arbiter: reset, read routing, contention,
// read/write toggle, backpressure and mid-transaction reset.
module tb_axil_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_ready;
   logic [3:0]  m0_ar_address, m0_aw_address;
   logic [31:0] m0_r_data, m0_w_data;
   logic [0:0]  m0_r_resp, m0_b_resp;
   logic        m0_aw_valid, m0_aw_ready, m0_w_valid, m0_w_ready, m0_b_valid, m0_b_ready;
   logic        m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_ready;
   logic [3:0]  m1_ar_address, m1_aw_address;
   logic [31:0] m1_r_data, m1_w_data;
   logic [0:0]  m1_r_resp, m1_b_resp;
   logic        m1_aw_valid, m1_aw_ready, m1_w_valid, m1_w_ready, m1_b_valid, m1_b_ready;
   logic        s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
   logic [3:0]  s_ar_address, s_aw_address;
   logic [31:0] s_r_data, s_w_data;
   logic [0:0]  s_r_resp, s_b_resp;
   logic        s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
   logic        busy, grant_id;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axil_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_ar_valid(m0_ar_valid), .m0_ar_address(m0_ar_address), .m0_ar_ready(m0_ar_ready),
      .m0_r_valid(m0_r_valid), .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp), .m0_r_ready(m0_r_ready),
      .m0_aw_valid(m0_aw_valid), .m0_aw_address(m0_aw_address), .m0_aw_ready(m0_aw_ready),
      .m0_w_valid(m0_w_valid), .m0_w_data(m0_w_data), .m0_w_ready(m0_w_ready),
      .m0_b_valid(m0_b_valid), .m0_b_resp(m0_b_resp), .m0_b_ready(m0_b_ready),
      .m1_ar_valid(m1_ar_valid), .m1_ar_address(m1_ar_address), .m1_ar_ready(m1_ar_ready),
      .m1_r_valid(m1_r_valid), .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp), .m1_r_ready(m1_r_ready),
      .m1_aw_valid(m1_aw_valid), .m1_aw_address(m1_aw_address), .m1_aw_ready(m1_aw_ready),
      .m1_w_valid(m1_w_valid), .m1_w_data(m1_w_data), .m1_w_ready(m1_w_ready),
      .m1_b_valid(m1_b_valid), .m1_b_resp(m1_b_resp), .m1_b_ready(m1_b_ready),
      .s_ar_valid(s_ar_valid), .s_ar_address(s_ar_address), .s_ar_ready(s_ar_ready),
      .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_ready(s_r_ready),
      .s_aw_valid(s_aw_valid), .s_aw_address(s_aw_address), .s_aw_ready(s_aw_ready),
      .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_ready(s_w_ready),
      .s_b_valid(s_b_valid), .s_b_resp(s_b_resp), .s_b_ready(s_b_ready),
      .busy(busy), .grant_id(grant_id)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_ar_valid = 0; m0_ar_address = '0; m0_r_ready = 0;
      m0_aw_valid = 0; m0_aw_address = '0; m0_w_valid = 0; m0_w_data = '0; m0_b_ready = 0;
      m1_ar_valid = 0; m1_ar_address = '0; m1_r_ready = 0;
      m1_aw_valid = 0; m1_aw_address = '0; m1_w_valid = 0; m1_w_data = '0; m1_b_ready = 0;
      s_ar_ready = 0; s_r_valid = 0; s_r_data = '0; s_r_resp = '0;
      s_aw_ready = 0; s_w_ready = 0; s_b_valid = 0; s_b_resp = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      m0_ar_valid = 1; m0_ar_address = 4'hA;
      m1_ar_valid = 1; m1_ar_address = 4'h3;
      tick();
      tick();
      n_vec++;
      if ({busy, grant_id, s_ar_valid, m0_ar_ready, m1_ar_ready, s_aw_valid, s_w_valid} !== 7'b0) begin
         $display("FAIL reset_ctrl got %b exp 0", {busy, grant_id, s_ar_valid, m0_ar_ready, m1_ar_ready, s_aw_valid, s_w_valid});
         n_err++;
      end
      n_vec++;
      if (s_ar_address !== 4'h0) begin
         $display("FAIL reset_addr got %h exp 0", s_ar_address); n_err++;
      end
      rst = 0;
      tick();
      n_vec++;
      if ({busy, grant_id, s_ar_valid, s_ar_address} !== {1'b1, 1'b0, 1'b1, 4'hA}) begin
         $display("FAIL reset_first_grant got %b exp 1011010", {busy, grant_id, s_ar_valid, s_ar_address}); n_err++;
      end
   endtask

   task automatic test_single_read();
      do_reset();
      m1_ar_valid = 1; m1_ar_address = 4'h5;
      tick();
      n_vec++;
      if ({busy, grant_id, s_ar_valid, s_ar_address} !== {1'b1, 1'b1, 1'b1, 4'h5}) begin
         $display("FAIL read_grant got %b exp 1111 0101", {busy, grant_id, s_ar_valid, s_ar_address}); n_err++;
      end
      s_ar_ready = 1;
      #1;
      n_vec++;
      if ({m1_ar_ready, m0_ar_ready} !== 2'b10) begin
         $display("FAIL read_ar_ready got %b exp 10", {m1_ar_ready, m0_ar_ready}); n_err++;
      end
      tick();
      m1_ar_valid = 0; s_ar_ready = 0;
      s_r_valid = 1; s_r_data = 32'hDEADBEEF; s_r_resp = 1'b1; m1_r_ready = 1;
      #1;
      n_vec++;
      if ({m1_r_valid, m1_r_data, m1_r_resp, s_r_ready} !== {1'b1, 32'hDEADBEEF, 1'b1, 1'b1}) begin
         $display("FAIL read_data got %b %h %b %b exp 1 deadbeef 1 1", m1_r_valid, m1_r_data, m1_r_resp, s_r_ready); n_err++;
      end
      n_vec++;
      if ({m0_r_valid, m0_r_data, m0_r_resp, m0_ar_ready, m0_b_valid} !== 36'h0) begin
         $display("FAIL read_m0_quiet got %b %h exp 0", m0_r_valid, m0_r_data); n_err++;
      end
      tick();
      s_r_valid = 0; m1_r_ready = 0;
      n_vec++;
      if ({busy, grant_id, m1_r_valid, m1_r_data} !== 35'h0) begin
         $display("FAIL read_done got %b %b %h exp 0", busy, grant_id, m1_r_data); n_err++;
      end
   endtask

   task automatic test_contention();
      do_reset();
      m0_aw_valid = 1; m0_aw_address = 4'h1; m0_w_valid = 1; m0_w_data = 32'h11; m0_b_ready = 1;
      m1_aw_valid = 1; m1_aw_address = 4'h2; m1_w_valid = 1; m1_w_data = 32'h22; m1_b_ready = 1;
      s_aw_ready = 1; s_w_ready = 1; s_b_valid = 1;
      tick();
      n_vec++;
      if ({grant_id, s_aw_valid, s_aw_address} !== {1'b0, 1'b1, 4'h1}) begin
         $display("FAIL cont_first_grant got %b exp 010001", {grant_id, s_aw_valid, s_aw_address}); n_err++;
      end
      tick();
      m0_aw_valid = 0;
      n_vec++;
      if ({s_w_valid, s_w_data} !== {1'b1, 32'h11}) begin
         $display("FAIL cont_wdata0 got %b %h exp 1 00000011", s_w_valid, s_w_data); n_err++;
      end
      tick();
      m0_w_valid = 0;
      n_vec++;
      if ({m0_b_valid, m1_b_valid, s_b_ready} !== 3'b101) begin
         $display("FAIL cont_bresp0 got %b exp 101", {m0_b_valid, m1_b_valid, s_b_ready}); n_err++;
      end
      tick();
      n_vec++;
      if ({busy, s_aw_valid, s_w_valid} !== 3'b000) begin
         $display("FAIL cont_idle_gap got %b exp 000", {busy, s_aw_valid, s_w_valid}); n_err++;
      end
      tick();
      n_vec++;
      if ({grant_id, s_aw_valid, s_aw_address} !== {1'b1, 1'b1, 4'h2}) begin
         $display("FAIL cont_second_grant got %b exp 110010", {grant_id, s_aw_valid, s_aw_address}); n_err++;
      end
      tick();
      m1_aw_valid = 0;
      n_vec++;
      if ({s_w_valid, s_w_data} !== {1'b1, 32'h22}) begin
         $display("FAIL cont_wdata1 got %b %h exp 1 00000022", s_w_valid, s_w_data); n_err++;
      end
   endtask

   task automatic test_rw_toggle();
      logic [2:0] seen;
      do_reset();
      m0_ar_valid = 1; m0_ar_address = 4'h7; m0_aw_valid = 1; m0_aw_address = 4'h8;
      m0_w_valid = 1; m0_w_data = 32'h33; m0_r_ready = 1; m0_b_ready = 1;
      s_ar_ready = 1; s_aw_ready = 1; s_w_ready = 1; s_r_valid = 1; s_b_valid = 1;
      tick();
      seen[2] = s_aw_valid;
      n_vec++;
      if ({s_ar_valid, s_aw_valid} !== 2'b10) begin
         $display("FAIL toggle_txn1 got %b exp 10 (read)", {s_ar_valid, s_aw_valid}); n_err++;
      end
      tick(); tick(); tick();
      seen[1] = s_aw_valid;
      n_vec++;
      if ({s_ar_valid, s_aw_valid, s_aw_address} !== {2'b01, 4'h8}) begin
         $display("FAIL toggle_txn2 got %b exp 011000 (write)", {s_ar_valid, s_aw_valid, s_aw_address}); n_err++;
      end
      tick(); tick(); tick(); tick();
      seen[0] = s_aw_valid;
      n_vec++;
      if ({s_ar_valid, s_aw_valid} !== 2'b10) begin
         $display("FAIL toggle_txn3 got %b exp 10 (read)", {s_ar_valid, s_aw_valid}); n_err++;
      end
      n_vec++;
      if (seen !== 3'b010) begin
         $display("FAIL toggle_order got %b exp 010", seen); n_err++;
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      m0_aw_valid = 1; m0_aw_address = 4'hC; m0_w_valid = 1; m0_w_data = 32'h44;
      tick();
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if ({busy, s_aw_valid, m0_aw_ready, s_w_valid} !== 4'b1100) begin
            $display("FAIL bp_aw_hold[%0d] got %b exp 1100", i, {busy, s_aw_valid, m0_aw_ready, s_w_valid}); n_err++;
         end
         tick();
      end
      s_aw_ready = 1;
      tick();
      m0_aw_valid = 0; s_aw_ready = 0; s_w_ready = 1;
      tick();
      m0_w_valid = 0; s_w_ready = 0; s_b_valid = 1; s_b_resp = 1'b1; m0_b_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_vec++;
         if ({busy, m0_b_valid, m0_b_resp, s_b_ready} !== 4'b1110) begin
            $display("FAIL bp_b_hold[%0d] got %b exp 1110", i, {busy, m0_b_valid, m0_b_resp, s_b_ready}); n_err++;
         end
         tick();
      end
      m0_b_ready = 1;
      #1;
      n_vec++;
      if ({m0_b_valid, s_b_ready} !== 2'b11) begin
         $display("FAIL bp_b_release got %b exp 11", {m0_b_valid, s_b_ready}); n_err++;
      end
      tick();
      s_b_valid = 0; m0_b_ready = 0;
      n_vec++;
      if ({busy, m0_b_valid} !== 2'b00) begin
         $display("FAIL bp_done got %b exp 00", {busy, m0_b_valid}); n_err++;
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      m0_aw_valid = 1; m0_aw_address = 4'h9; m0_w_valid = 1; m0_w_data = 32'h55;
      s_aw_ready = 1;
      tick();
      tick();
      m0_aw_valid = 0; s_aw_ready = 0;
      n_vec++;
      if ({busy, s_w_valid, s_w_data} !== {2'b11, 32'h55}) begin
         $display("FAIL midrst_in_wdata got %b %b %h exp 1 1 00000055", busy, s_w_valid, s_w_data); n_err++;
      end
      rst = 1;
      tick();
      n_vec++;
      if ({busy, s_w_valid, s_w_data, grant_id} !== 35'h0) begin
         $display("FAIL midrst_cleared got %b %b %h %b exp 0", busy, s_w_valid, s_w_data, grant_id); n_err++;
      end
      rst = 0;
      m0_w_valid = 0;
      m0_ar_valid = 1; m0_ar_address = 4'h1;
      m1_ar_valid = 1; m1_ar_address = 4'h2;
      tick();
      n_vec++;
      if ({grant_id, s_ar_valid, s_ar_address} !== {2'b01, 4'h1}) begin
         $display("FAIL midrst_next_grant got %b exp 010001", {grant_id, s_ar_valid, s_ar_address}); n_err++;
      end
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      test_reset();
      test_single_read();
      test_contention();
      test_rw_toggle();
      test_backpressure();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
